// File: rtl/bf_bus_bridge.sv
// bf_bus_bridge
// Bridges a single-request core interface onto a narrow beat-serial bus.
// A transaction is sent as an op beat, then the address beats, then the write
// data beats for write-type ops. The bridge then waits for the external agent.
// Reads collect DATA_BEATS inbound beats. Writes complete on the first op_done.
// Either kind also completes when the wait times out.
//
// Ports
//   clock, reset       sole clock; asynchronous active-high reset
//   enable             global advance; low freezes every register
//   req_valid/ready    core request handshake
//   req_op/addr/wdata  request op code (bit0 = write-type), address, write data
//   rsp_valid          one-cycle response pulse
//   rsp_rdata          read data (zero for writes and timeouts)
//   rsp_error          response caused by a timeout
//   bus_out            outbound bus beat
//   bus_in, op_done    inbound beat and agent beat/completion strobe
//   bus_phase          current state encoding
//   busy               high when not in IDLE
//
// state | meaning
// IDLE  | ready for a request
// OP    | op code beat on bus_out
// ADDR  | address beats, MSB beat first
// DATA  | write data beats, MSB beat first
// WAIT  | waiting for agent beats / completion, timeout running
// RESP  | rsp_valid pulse, then back to IDLE
module bf_bus_bridge #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [BUS_WIDTH-1:0]  bus_out,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    input  logic                  op_done,
    output logic [2:0]            bus_phase,
    output logic                  busy
);

    localparam int ADDR_BEATS = (ADDR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int DATA_BEATS = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int ADDR_PAD   = ADDR_BEATS * BUS_WIDTH;
    localparam int DATA_PAD   = DATA_BEATS * BUS_WIDTH;
    localparam int MAX_BEATS  = (ADDR_BEATS > DATA_BEATS) ? ADDR_BEATS : DATA_BEATS;
    localparam int BCW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int TCW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OP   = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            op_q;
    logic [ADDR_PAD-1:0]   addr_q;
    logic [DATA_PAD-1:0]   wdata_q;
    logic [DATA_PAD-1:0]   rd_sh;
    logic [DATA_PAD-1:0]   rd_sh_nxt;
    logic [DATA_PAD+BUS_WIDTH-1:0] rd_cat;
    logic [BCW-1:0]        beat_cnt;
    logic [TCW-1:0]        tmo_cnt;
    logic [TCW-1:0]        tmo_inc;
    logic                  tmo_hit;
    logic                  accept;

    // Beat counter runs down, so its value directly indexes the beat to drive
    // and the MSB beat goes out first.
    assign accept    = req_valid && (req_op != 3'd0);
    assign rd_cat    = {rd_sh, bus_in};
    assign rd_sh_nxt = rd_cat[DATA_PAD-1:0];
    assign tmo_inc   = tmo_cnt + TCW'(1);
    // Fires on the idle WAIT cycle that would bring the counter to TIMEOUT.
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_inc == TCW'(TIMEOUT));

    assign req_ready = enable && (state == S_IDLE);
    assign rsp_valid = enable && (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign bus_phase = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else if (enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus_out   = '0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_OP;
            end
            S_OP: begin
                bus_out   = BUS_WIDTH'(op_q);
                state_nxt = S_ADDR;
            end
            S_ADDR: begin
                bus_out = addr_q[int'(beat_cnt)*BUS_WIDTH +: BUS_WIDTH];
                if (beat_cnt == '0) state_nxt = op_q[0] ? S_DATA : S_WAIT;
            end
            S_DATA: begin
                bus_out = wdata_q[int'(beat_cnt)*BUS_WIDTH +: BUS_WIDTH];
                if (beat_cnt == '0) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (op_done) begin
                    if (op_q[0] || (beat_cnt == '0)) state_nxt = S_RESP;
                end else if (tmo_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_sh     <= '0;
            beat_cnt  <= '0;
            tmo_cnt   <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        addr_q  <= ADDR_PAD'(req_addr);
                        wdata_q <= DATA_PAD'(req_wdata);
                    end
                end
                S_OP: begin
                    beat_cnt <= BCW'(ADDR_BEATS - 1);
                end
                S_ADDR: begin
                    if (beat_cnt == '0) begin
                        // Reload for the data beats (writes) or the read beats
                        // to collect (reads); both are DATA_BEATS long.
                        beat_cnt <= BCW'(DATA_BEATS - 1);
                        tmo_cnt  <= '0;
                        rd_sh    <= '0;
                    end else begin
                        beat_cnt <= beat_cnt - BCW'(1);
                    end
                end
                S_DATA: begin
                    if (beat_cnt == '0) begin
                        tmo_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt - BCW'(1);
                    end
                end
                S_WAIT: begin
                    if (op_done) begin
                        tmo_cnt <= '0;
                        if (op_q[0]) begin
                            rsp_rdata <= '0;
                            rsp_error <= 1'b0;
                        end else begin
                            rd_sh <= rd_sh_nxt;
                            if (beat_cnt == '0) begin
                                rsp_rdata <= rd_sh_nxt[DATA_WIDTH-1:0];
                                rsp_error <= 1'b0;
                            end else begin
                                beat_cnt <= beat_cnt - BCW'(1);
                            end
                        end
                    end else if (tmo_hit) begin
                        rsp_rdata <= '0;
                        rsp_error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_bus_bridge.sv
module tb_bf_bus_bridge;

    logic        clock;
    logic        reset;
    logic        enable;

    logic        a_req_valid, a_req_ready;
    logic [2:0]  a_req_op;
    logic [14:0] a_req_addr;
    logic [7:0]  a_req_wdata;
    logic        a_rsp_valid, a_rsp_error;
    logic [7:0]  a_rsp_rdata;
    logic [7:0]  a_bus_out, a_bus_in;
    logic        a_op_done;
    logic [2:0]  a_bus_phase;
    logic        a_busy;

    logic        b_req_valid, b_req_ready;
    logic [2:0]  b_req_op;
    logic [14:0] b_req_addr;
    logic [15:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_error;
    logic [15:0] b_rsp_rdata;
    logic [7:0]  b_bus_out, b_bus_in;
    logic        b_op_done;
    logic [2:0]  b_bus_phase;
    logic        b_busy;

    int n_pass;
    int n_total;

    bf_bus_bridge #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .BUS_WIDTH(8), .TIMEOUT(8)) dut_a (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_op(a_req_op),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error),
        .bus_out(a_bus_out), .bus_in(a_bus_in), .op_done(a_op_done),
        .bus_phase(a_bus_phase), .busy(a_busy)
    );

    bf_bus_bridge #(.ADDR_WIDTH(15), .DATA_WIDTH(16), .BUS_WIDTH(8), .TIMEOUT(64)) dut_b (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error),
        .bus_out(b_bus_out), .bus_in(b_bus_in), .op_done(b_op_done),
        .bus_phase(b_bus_phase), .busy(b_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        n_total++;
        if ({a_bus_phase, a_busy, a_rsp_valid, a_bus_out, a_rsp_rdata, a_rsp_error} !== 22'd0)
            $display("FAIL reset_a_outputs: got phase=%0d busy=%b vld=%b bus=%h rd=%h err=%b, want all zero",
                     a_bus_phase, a_busy, a_rsp_valid, a_bus_out, a_rsp_rdata, a_rsp_error);
        else n_pass++;
        n_total++;
        if ({b_bus_phase, b_busy, b_rsp_rdata, b_rsp_error} !== 21'd0)
            $display("FAIL reset_b_outputs: got phase=%0d busy=%b rd=%h err=%b, want all zero",
                     b_bus_phase, b_busy, b_rsp_rdata, b_rsp_error);
        else n_pass++;
        reset = 1'b0;
        step;
        n_total++;
        if (a_req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", a_req_ready);
        else n_pass++;
    endtask

    task automatic test_read;
        logic [7:0] eb [6];
        logic [2:0] ep [6];
        eb = '{8'h04, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00};
        ep = '{3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4};
        a_req_valid = 1'b1; a_req_op = 3'b100; a_req_addr = 15'h1234;
        n_total++;
        if (a_req_ready !== 1'b1) $display("FAIL read_ready_idle: got %b want 1", a_req_ready);
        else n_pass++;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if ({a_bus_out, a_bus_phase, a_rsp_valid, a_req_ready} !== {eb[i], ep[i], 1'b0, 1'b0})
                $display("FAIL read_seq[%0d]: got bus=%h phase=%0d vld=%b rdy=%b want bus=%h phase=%0d vld=0 rdy=0",
                         i, a_bus_out, a_bus_phase, a_rsp_valid, a_req_ready, eb[i], ep[i]);
            else n_pass++;
            if (i == 5) begin a_op_done = 1'b1; a_bus_in = 8'hA5; end
            step;
        end
        a_op_done = 1'b0; a_bus_in = 8'h00;
        n_total++;
        if ({a_rsp_valid, a_rsp_rdata, a_rsp_error, a_bus_phase, a_bus_out} !== {1'b1, 8'hA5, 1'b0, 3'd5, 8'h00})
            $display("FAIL read_resp: got vld=%b rd=%h err=%b phase=%0d bus=%h want vld=1 rd=a5 err=0 phase=5 bus=00",
                     a_rsp_valid, a_rsp_rdata, a_rsp_error, a_bus_phase, a_bus_out);
        else n_pass++;
        step;
        n_total++;
        if ({a_rsp_valid, a_bus_phase, a_rsp_rdata} !== {1'b0, 3'd0, 8'hA5})
            $display("FAIL read_after: got vld=%b phase=%0d rd=%h want vld=0 phase=0 rd=a5",
                     a_rsp_valid, a_bus_phase, a_rsp_rdata);
        else n_pass++;
    endtask

    task automatic test_timeout;
        logic [7:0] exp_bus;
        logic [2:0] exp_ph;
        a_req_valid = 1'b1; a_req_op = 3'b110; a_req_addr = 15'h0042;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        for (int i = 0; i < 11; i++) begin
            exp_ph  = (i == 0) ? 3'd1 : (i < 3) ? 3'd2 : 3'd4;
            exp_bus = (i == 0) ? 8'h06 : (i == 2) ? 8'h42 : 8'h00;
            n_total++;
            if ({a_bus_out, a_bus_phase, a_rsp_valid} !== {exp_bus, exp_ph, 1'b0})
                $display("FAIL timeout_seq[%0d]: got bus=%h phase=%0d vld=%b want bus=%h phase=%0d vld=0",
                         i, a_bus_out, a_bus_phase, a_rsp_valid, exp_bus, exp_ph);
            else n_pass++;
            step;
        end
        n_total++;
        if ({a_rsp_valid, a_rsp_error, a_rsp_rdata} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL timeout_resp: got vld=%b err=%b rd=%h want vld=1 err=1 rd=00",
                     a_rsp_valid, a_rsp_error, a_rsp_rdata);
        else n_pass++;
        step;
        n_total++;
        if ({a_bus_phase, a_rsp_valid, a_busy} !== {3'd0, 1'b0, 1'b0})
            $display("FAIL timeout_idle: got phase=%0d vld=%b busy=%b want 0 0 0", a_bus_phase, a_rsp_valid, a_busy);
        else n_pass++;
    endtask

    task automatic test_write;
        logic [7:0] eb [5];
        logic [2:0] ep [5];
        eb = '{8'h05, 8'h7F, 8'hFF, 8'h3C, 8'h00};
        ep = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
        a_req_valid = 1'b1; a_req_op = 3'b101; a_req_addr = 15'h7FFF; a_req_wdata = 8'h3C;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({a_bus_out, a_bus_phase, a_rsp_valid} !== {eb[i], ep[i], 1'b0})
                $display("FAIL write_seq[%0d]: got bus=%h phase=%0d vld=%b want bus=%h phase=%0d vld=0",
                         i, a_bus_out, a_bus_phase, a_rsp_valid, eb[i], ep[i]);
            else n_pass++;
            if (i == 4) begin a_op_done = 1'b1; a_bus_in = 8'h99; end
            step;
        end
        a_op_done = 1'b0; a_bus_in = 8'h00;
        n_total++;
        if ({a_rsp_valid, a_rsp_rdata, a_rsp_error} !== {1'b1, 8'h00, 1'b0})
            $display("FAIL write_resp: got vld=%b rd=%h err=%b want vld=1 rd=00 err=0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_error);
        else n_pass++;
        step;
    endtask

    task automatic test_done_ignored;
        logic [7:0] eb [5];
        logic [2:0] ep [5];
        eb = '{8'h01, 8'h00, 8'h00, 8'h55, 8'h00};
        ep = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
        a_req_valid = 1'b1; a_req_op = 3'b001; a_req_addr = 15'h0000; a_req_wdata = 8'h55;
        a_op_done = 1'b1; a_bus_in = 8'hEE;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({a_bus_out, a_bus_phase, a_rsp_valid} !== {eb[i], ep[i], 1'b0})
                $display("FAIL done_ign_seq[%0d]: got bus=%h phase=%0d vld=%b want bus=%h phase=%0d vld=0",
                         i, a_bus_out, a_bus_phase, a_rsp_valid, eb[i], ep[i]);
            else n_pass++;
            step;
        end
        a_op_done = 1'b0; a_bus_in = 8'h00;
        n_total++;
        if ({a_rsp_valid, a_rsp_rdata, a_bus_phase} !== {1'b1, 8'h00, 3'd5})
            $display("FAIL done_ign_resp: got vld=%b rd=%h phase=%0d want vld=1 rd=00 phase=5",
                     a_rsp_valid, a_rsp_rdata, a_bus_phase);
        else n_pass++;
        step;
    endtask

    task automatic test_op_zero;
        a_req_valid = 1'b1; a_req_op = 3'd0; a_req_addr = 15'h1111;
        n_total++;
        if (a_req_ready !== 1'b1) $display("FAIL opzero_ready: got %b want 1", a_req_ready);
        else n_pass++;
        step;
        a_req_valid = 1'b0;
        n_total++;
        if ({a_bus_phase, a_busy, a_rsp_valid} !== {3'd0, 1'b0, 1'b0})
            $display("FAIL opzero_idle: got phase=%0d busy=%b vld=%b want 0 0 0", a_bus_phase, a_busy, a_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        a_req_valid = 1'b1; a_req_op = 3'b100; a_req_addr = 15'h0001;
        step;
        a_req_valid = 1'b0;
        step; step; step;
        a_op_done = 1'b1; a_bus_in = 8'h11;
        step;
        a_op_done = 1'b0;
        n_total++;
        if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, 8'h11})
            $display("FAIL b2b_resp1: got vld=%b rd=%h want vld=1 rd=11", a_rsp_valid, a_rsp_rdata);
        else n_pass++;
        step;
        n_total++;
        if ({a_bus_phase, a_req_ready} !== {3'd0, 1'b1})
            $display("FAIL b2b_idle: got phase=%0d rdy=%b want phase=0 rdy=1", a_bus_phase, a_req_ready);
        else n_pass++;
        a_req_valid = 1'b1; a_req_op = 3'b010; a_req_addr = 15'h0002;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        n_total++;
        if ({a_bus_phase, a_bus_out} !== {3'd1, 8'h02})
            $display("FAIL b2b_op2: got phase=%0d bus=%h want phase=1 bus=02", a_bus_phase, a_bus_out);
        else n_pass++;
        step; step; step;
        n_total++;
        if (a_bus_phase !== 3'd4) $display("FAIL b2b_wait2: got phase=%0d want 4", a_bus_phase);
        else n_pass++;
        a_op_done = 1'b1; a_bus_in = 8'h22;
        step;
        a_op_done = 1'b0;
        n_total++;
        if ({a_rsp_valid, a_rsp_rdata, a_rsp_error} !== {1'b1, 8'h22, 1'b0})
            $display("FAIL b2b_resp2: got vld=%b rd=%h err=%b want vld=1 rd=22 err=0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_error);
        else n_pass++;
        step;
    endtask

    task automatic test_enable;
        a_req_valid = 1'b1; a_req_op = 3'b100; a_req_addr = 15'h1234;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        step;
        n_total++;
        if ({a_bus_phase, a_bus_out} !== {3'd2, 8'h12})
            $display("FAIL en_beat1: got phase=%0d bus=%h want phase=2 bus=12", a_bus_phase, a_bus_out);
        else n_pass++;
        enable = 1'b0; a_op_done = 1'b1; a_bus_in = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step;
            n_total++;
            if ({a_bus_phase, a_bus_out, a_req_ready, a_rsp_valid} !== {3'd2, 8'h12, 1'b0, 1'b0})
                $display("FAIL en_hold[%0d]: got phase=%0d bus=%h rdy=%b vld=%b want phase=2 bus=12 rdy=0 vld=0",
                         i, a_bus_phase, a_bus_out, a_req_ready, a_rsp_valid);
            else n_pass++;
        end
        enable = 1'b1; a_op_done = 1'b0;
        step;
        n_total++;
        if ({a_bus_phase, a_bus_out} !== {3'd2, 8'h34})
            $display("FAIL en_beat0: got phase=%0d bus=%h want phase=2 bus=34", a_bus_phase, a_bus_out);
        else n_pass++;
        step;
        enable = 1'b0; a_op_done = 1'b1; a_bus_in = 8'hFF;
        step; step;
        n_total++;
        if ({a_bus_phase, a_rsp_valid} !== {3'd4, 1'b0})
            $display("FAIL en_wait_hold: got phase=%0d vld=%b want phase=4 vld=0", a_bus_phase, a_rsp_valid);
        else n_pass++;
        enable = 1'b1; a_bus_in = 8'h5A;
        step;
        a_op_done = 1'b0;
        n_total++;
        if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, 8'h5A})
            $display("FAIL en_resp: got vld=%b rd=%h want vld=1 rd=5a", a_rsp_valid, a_rsp_rdata);
        else n_pass++;
        step;
    endtask

    task automatic test_reset_mid;
        a_req_valid = 1'b1; a_req_op = 3'b100; a_req_addr = 15'h1234;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        step;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({a_bus_phase, a_busy, a_bus_out, a_rsp_rdata, a_rsp_valid} !== {3'd0, 1'b0, 8'h00, 8'h00, 1'b0})
            $display("FAIL rstmid_async: got phase=%0d busy=%b bus=%h rd=%h vld=%b want all zero",
                     a_bus_phase, a_busy, a_bus_out, a_rsp_rdata, a_rsp_valid);
        else n_pass++;
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step;
            n_total++;
            if ({a_bus_phase, a_rsp_valid} !== {3'd0, 1'b0})
                $display("FAIL rstmid_quiet[%0d]: got phase=%0d vld=%b want phase=0 vld=0", i, a_bus_phase, a_rsp_valid);
            else n_pass++;
        end
        a_req_valid = 1'b1; a_req_op = 3'b100; a_req_addr = 15'h0055;
        step;
        a_req_valid = 1'b0; a_req_op = 3'd0;
        step; step; step;
        a_op_done = 1'b1; a_bus_in = 8'h77;
        step;
        a_op_done = 1'b0;
        n_total++;
        if ({a_rsp_valid, a_rsp_rdata, a_rsp_error} !== {1'b1, 8'h77, 1'b0})
            $display("FAIL rstmid_next: got vld=%b rd=%h err=%b want vld=1 rd=77 err=0",
                     a_rsp_valid, a_rsp_rdata, a_rsp_error);
        else n_pass++;
        step;
    endtask

    task automatic test_wide;
        logic [7:0] eb [6];
        logic [2:0] ep [6];
        eb = '{8'h01, 8'h00, 8'h10, 8'hBE, 8'hEF, 8'h00};
        ep = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
        b_req_valid = 1'b1; b_req_op = 3'b001; b_req_addr = 15'h0010; b_req_wdata = 16'hBEEF;
        step;
        b_req_valid = 1'b0; b_req_op = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if ({b_bus_out, b_bus_phase} !== {eb[i], ep[i]})
                $display("FAIL wide_wr_seq[%0d]: got bus=%h phase=%0d want bus=%h phase=%0d",
                         i, b_bus_out, b_bus_phase, eb[i], ep[i]);
            else n_pass++;
            if (i == 5) b_op_done = 1'b1;
            step;
        end
        b_op_done = 1'b0;
        n_total++;
        if ({b_rsp_valid, b_rsp_rdata, b_rsp_error} !== {1'b1, 16'h0000, 1'b0})
            $display("FAIL wide_wr_resp: got vld=%b rd=%h err=%b want vld=1 rd=0000 err=0",
                     b_rsp_valid, b_rsp_rdata, b_rsp_error);
        else n_pass++;
        step;
        eb = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        ep = '{3'd1, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4};
        b_req_valid = 1'b1; b_req_op = 3'b010; b_req_addr = 15'h0003;
        step;
        b_req_valid = 1'b0; b_req_op = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if ({b_bus_out, b_bus_phase, b_rsp_valid} !== {eb[i], ep[i], 1'b0})
                $display("FAIL wide_rd_seq[%0d]: got bus=%h phase=%0d vld=%b want bus=%h phase=%0d vld=0",
                         i, b_bus_out, b_bus_phase, b_rsp_valid, eb[i], ep[i]);
            else n_pass++;
            if (i == 3) begin b_op_done = 1'b1; b_bus_in = 8'h12; end
            if (i == 4) begin b_op_done = 1'b0; b_bus_in = 8'h00; end
            if (i == 5) begin b_op_done = 1'b1; b_bus_in = 8'h34; end
            step;
        end
        b_op_done = 1'b0; b_bus_in = 8'h00;
        n_total++;
        if ({b_rsp_valid, b_rsp_rdata, b_rsp_error} !== {1'b1, 16'h1234, 1'b0})
            $display("FAIL wide_rd_resp: got vld=%b rd=%h err=%b want vld=1 rd=1234 err=0",
                     b_rsp_valid, b_rsp_rdata, b_rsp_error);
        else n_pass++;
        step;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; enable = 1'b1;
        a_req_valid = 1'b0; a_req_op = 3'd0; a_req_addr = '0; a_req_wdata = '0;
        a_bus_in = '0; a_op_done = 1'b0;
        b_req_valid = 1'b0; b_req_op = 3'd0; b_req_addr = '0; b_req_wdata = '0;
        b_bus_in = '0; b_op_done = 1'b0;
        step; step;
        test_reset;
        test_read;
        test_timeout;
        test_write;
        test_done_ignored;
        test_op_zero;
        test_back_to_back;
        test_enable;
        test_reset_mid;
        test_wide;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bf_bus_bridge.md
BF_BUS_BRIDGE -- requirements
Module: bf_bus_bridge

Interface
REQ-001 Param ADDR_WIDTH, 15, request address width in bits.
REQ-002 Param DATA_WIDTH, 8, request/response data width in bits.
REQ-003 Param BUS_WIDTH, 8, external bus width in bits; must be at least 3.
REQ-004 Param TIMEOUT, 64, WAIT-phase cycle limit; 0 disables timeout; counter width is $clog2(TIMEOUT+1).
REQ-005 Derived constants: ADDR_BEATS = ceil(ADDR_WIDTH/BUS_WIDTH) and DATA_BEATS = ceil(DATA_WIDTH/BUS_WIDTH).
REQ-006 clock  in  1  sole clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-008 enable  in  1  global advance; low freezes all registers.
REQ-009 req_valid  in  1  core request present.
REQ-010 req_ready  out  1  bridge accepts a request this cycle.
REQ-011 req_op  in  3  op code; 0 = none; bit0 = 1 means write-type.
REQ-012 req_addr  in  ADDR_WIDTH  request address.
REQ-013 req_wdata  in  DATA_WIDTH  write data.
REQ-014 rsp_valid  out  1  response pulse.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data.
REQ-016 rsp_error  out  1  transaction timed out.
REQ-017 bus_out  out  BUS_WIDTH  outbound bus beat.
REQ-018 bus_in  in  BUS_WIDTH  inbound bus beat.
REQ-019 op_done  in  1  external agent beat or completion strobe.
REQ-020 bus_phase  out  3  current FSM state encoding.
REQ-021 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-022 FSM state encodings: IDLE=0, OP=1, ADDR=2, DATA=3, WAIT=4, RESP=5; any other value returns to IDLE on the next enabled edge.
REQ-023 req_ready = enable && (state==IDLE).
REQ-024 Acceptance: req_valid && req_ready && req_op!=0 latches op, addr and wdata and moves to OP.
REQ-025 A request with req_op==0 is consumed with no transaction started.
REQ-026 OP: bus_out = zero-extended latched op; lasts 1 cycle.
REQ-027 ADDR: lasts ADDR_BEATS cycles, one beat per cycle.
REQ-028 ADDR beat order: most-significant beat first; the top beat is zero-padded.
REQ-029 After ADDR: write-type ops go to DATA; read-type ops go to WAIT.
REQ-030 DATA: lasts DATA_BEATS cycles, MSB beat first, zero-padded.
REQ-031 WAIT: bus_out=0.
REQ-032 WAIT, read-type: each cycle with op_done high captures bus_in as the next beat, MSB first.
REQ-033 WAIT, read-type: after DATA_BEATS captured beats, go to RESP.
REQ-034 WAIT, write-type: the first op_done high goes to RESP.
REQ-035 Timeout counter: clears on WAIT entry and on every op_done beat; increments on each enabled WAIT cycle without op_done.
REQ-036 Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP with error set and rdata=0.
REQ-037 RESP: rsp_valid=1 for exactly one enabled cycle, with rsp_rdata and rsp_error valid; then go to IDLE.
REQ-038 rsp_rdata=0 for write-type ops.
REQ-039 No response backpressure.
REQ-040 Outside RESP, rsp_valid=0; rsp_rdata and rsp_error hold their last value.
REQ-041 In IDLE and RESP, bus_out=0.
REQ-042 enable low: state, beat counters, timeout counter and latches hold; op_done and bus_in are ignored; combinational outputs reflect the held state.
REQ-043 Latency with default parameters: read accepted at cycle 0 gives OP@1, ADDR@2-3, WAIT@4; op_done at 4 gives rsp_valid@5.
REQ-044 Latency with default parameters: write accepted at cycle 0 gives DATA@4, WAIT@5; op_done at 5 gives rsp_valid@6.
REQ-045 op_done high during OP, ADDR or DATA is ignored.

Reset
REQ-046 Reset asserted forces state=IDLE, all counters=0, latched op/addr/wdata=0, rsp_rdata=0, rsp_error=0, rsp_valid=0, bus_out=0, busy=0, independent of clock.
REQ-047 Reset mid-transaction discards partial beats and produces no response.
REQ-048 After reset release, the first enabled edge may accept a new request.

Verification
REQ-049 Read test: op=3'b100, addr=15'h1234; op_done with bus_in=8'hA5 on 3rd WAIT cycle. Required: bus_out sequence 04,12,34,00,00,00; one rsp_valid with rdata=8'hA5, error=0.
REQ-050 Write test: op=3'b101, addr=15'h7FFF, wdata=8'h3C; op_done on 1st WAIT cycle. Required: bus_out sequence 05,7F,FF,3C; rsp_valid, rdata=0, error=0.
REQ-051 Timeout test (TIMEOUT=8): read with op_done held low. Required: rsp_valid with error=1 and rdata=0 after 8 WAIT cycles; returns to IDLE.
REQ-052 Reset test: assert reset mid-ADDR between clock edges. Required: bus_phase=0 immediately; no rsp_valid; next request completes normally.
REQ-053 Enable test: drop enable for 5 cycles in ADDR beat 1. Required: bus_out holds 8'h12; beat order is unchanged after resume.
REQ-054 Wide-data test (DATA_WIDTH=16, BUS_WIDTH=8): write 16'hBEEF gives data beats BE,EF; read with op_done beats 12,34 gives rdata=16'h1234.
